alu_operand_sequencer: RTL and testbench

- Front-end controller that sits directly upstream of the 4-bit ADDER/ALU stage.
- Operands V1 and V2 and the 3-bit opcode OP are entered one at a time from switches, each confirmed by a press of an `enter` button.
- The block drives the registered values into the combinational adder, captures its result `R` and overflow/carry `ovf` into a result register, and holds them for display.
- A saturating count of overflowed operations is also kept.

---
 rtl/alu_operand_sequencer.sv | 140 ++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// Operand/opcode entry sequencer for the 4-bit ADDER/ALU stage: loads V1, V2, OP on button
// presses, captures the adder result, and keeps a saturating overflow count.
// Optional two-flop input synchronizers on enter/clear: define ALU_SEQ_INPUT_SYNC_EN.
module alu_operand_sequencer #(
   parameter int W   = 4,
   parameter int OPW = 3,
   parameter int CW  = 4
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [W-1:0]   sw,
   input  logic [OPW-1:0] op_sw,
   input  logic           enter,
   input  logic           clear,
   output logic [W-1:0]   V1,
   output logic [W-1:0]   V2,
   output logic [OPW-1:0] OP,
   input  logic [W-1:0]   R_in,
   input  logic           ovf_in,
   output logic [W-1:0]   result,
   output logic           result_ovf,
   output logic [CW-1:0]  ovf_cnt,
   output logic [2:0]     state,
   output logic           done
);

   typedef enum logic [2:0] {
      WAIT_A  = 3'd0,
      WAIT_B  = 3'd1,
      WAIT_OP = 3'd2,
      EXEC    = 3'd3,
      SHOW    = 3'd4
   } state_t;

   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   state_t         state_reg, state_next;
   logic [W-1:0]   v1_reg, v2_reg, result_reg;
   logic [OPW-1:0] op_reg;
   logic           result_ovf_reg, done_reg;
   logic [CW-1:0]  ovf_cnt_reg;
   logic           enter_s, clear_s, enter_q_reg, press;
   logic           load_a, load_b, load_op, capture;

`ifdef ALU_SEQ_INPUT_SYNC_EN
   logic [1:0] enter_sync_reg, clear_sync_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         enter_sync_reg <= 2'b00;
         clear_sync_reg <= 2'b00;
      end else begin
         enter_sync_reg <= {enter_sync_reg[0], enter};
         clear_sync_reg <= {clear_sync_reg[0], clear};
      end
   end

   assign enter_s = enter_sync_reg[1];
   assign clear_s = clear_sync_reg[1];
`else
   assign enter_s = enter;
   assign clear_s = clear;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) enter_q_reg <= 1'b0;
      else     enter_q_reg <= enter_s;
   end

   // One press per rising edge of the (possibly synchronized) button level
   assign press = enter_s & ~enter_q_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= WAIT_A;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      load_a     = 1'b0;
      load_b     = 1'b0;
      load_op    = 1'b0;
      capture    = 1'b0;
      if (clear_s) begin
         state_next = WAIT_A;
      end else begin
         case (state_reg)
            WAIT_A:  if (press) begin load_a  = 1'b1; state_next = WAIT_B;  end
            WAIT_B:  if (press) begin load_b  = 1'b1; state_next = WAIT_OP; end
            WAIT_OP: if (press) begin load_op = 1'b1; state_next = EXEC;    end
            EXEC:    begin capture = 1'b1; state_next = SHOW; end
            SHOW:    if (press) state_next = WAIT_A;
            default: state_next = WAIT_A;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1_reg         <= '0;
         v2_reg         <= '0;
         op_reg         <= '0;
         result_reg     <= '0;
         result_ovf_reg <= 1'b0;
         ovf_cnt_reg    <= '0;
         done_reg       <= 1'b0;
      end else if (clear_s) begin
         v1_reg         <= '0;
         v2_reg         <= '0;
         op_reg         <= '0;
         result_reg     <= '0;
         result_ovf_reg <= 1'b0;
         ovf_cnt_reg    <= '0;
         done_reg       <= 1'b0;
      end else begin
         if (load_a)  v1_reg <= sw;
         if (load_b)  v2_reg <= sw;
         if (load_op) op_reg <= op_sw;
         // done is high for the cycle after EXEC, i.e. the first SHOW cycle
         done_reg <= capture;
         if (capture) begin
            result_reg     <= R_in;
            result_ovf_reg <= ovf_in;
            if (ovf_in && (ovf_cnt_reg != CNT_MAX))
               ovf_cnt_reg <= ovf_cnt_reg + CNT_ONE;
         end
      end
   end

   assign V1         = v1_reg;
   assign V2         = v2_reg;
   assign OP         = op_reg;
   assign result     = result_reg;
   assign result_ovf = result_ovf_reg;
   assign ovf_cnt    = ovf_cnt_reg;
   assign state      = state_reg;
   assign done       = done_reg;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed + randomized bench for alu_operand_sequencer with an ADDER model in the loop
// and a transaction-level reference of the operand/result/overflow-count behaviour.
module tb_alu_operand_sequencer;

`ifdef ALU_SEQ_INPUT_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       clk, rst, enter, clear, ovf_in, result_ovf, done;
   logic [3:0] sw, V1, V2, R_in, result, ovf_cnt;
   logic [2:0] op_sw, OP, state;

   int vecs = 0;
   int errs = 0;
   int exp_cnt = 0;

   alu_operand_sequencer #(.W(4), .OPW(3), .CW(4)) dut (
      .clk(clk), .rst(rst), .sw(sw), .op_sw(op_sw), .enter(enter), .clear(clear),
      .V1(V1), .V2(V2), .OP(OP), .R_in(R_in), .ovf_in(ovf_in),
      .result(result), .result_ovf(result_ovf), .ovf_cnt(ovf_cnt),
      .state(state), .done(done)
   );

   // ADDER/ALU environment model: bit 4 is carry (add) or borrow (sub)
   function automatic logic [4:0] adder(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] o);
      case (o)
         3'd0:    return {1'b0, a} + {1'b0, b};
         3'd1:    return {1'b0, a} - {1'b0, b};
         3'd2:    return {1'b0, a & b};
         3'd3:    return {1'b0, a | b};
         3'd4:    return {1'b0, a ^ b};
         default: return {1'b0, a} + {1'b0, b} + 5'd1;
      endcase
   endfunction

   always_comb {ovf_in, R_in} = adder(V1, V2, OP);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vecs++;
      assert (obs === expv)
      else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Idle cycle with enter low, then a press held for 'hold' edges; returns once it has acted
   task automatic press(input logic [3:0] s, input logic [2:0] o, input int hold);
      enter = 1'b0;
      tick();
      sw = s;
      op_sw = o;
      enter = 1'b1;
      repeat (hold) tick();
      enter = 1'b0;
      repeat (LAT) tick();
   endtask

   task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] o);
      logic [4:0] r;
      r = adder(a, b, o);
      press(a, 3'($urandom), 1);
      chk("load_v1", 32'(V1), 32'(a));
      chk("state_b", 32'(state), 32'd1);
      press(b, 3'($urandom), 1);
      chk("load_v2", 32'(V2), 32'(b));
      chk("state_op", 32'(state), 32'd2);
      press(4'($urandom), o, 1);
      chk("load_op", 32'(OP), 32'(o));
      chk("state_exec", 32'(state), 32'd3);
      chk("done_in_exec", 32'(done), 32'd0);
      tick();
      if (r[4] && exp_cnt < 15) exp_cnt++;
      chk("result", 32'(result), 32'(r[3:0]));
      chk("result_ovf", 32'(result_ovf), 32'(r[4]));
      chk("done_pulse", 32'(done), 32'd1);
      chk("state_show", 32'(state), 32'd4);
      chk("ovf_cnt", 32'(ovf_cnt), 32'(exp_cnt));
      tick();
      chk("done_low", 32'(done), 32'd0);
      press(4'($urandom), 3'($urandom), 1);
      chk("state_back_a", 32'(state), 32'd0);
      chk("v1_held", 32'(V1), 32'(a));
      chk("result_held", 32'(result), 32'(r[3:0]));
      $display("op a=%0d b=%0d op=%0d -> r=%0d ovf=%0d cnt=%0d", a, b, o, r[3:0], r[4], exp_cnt);
   endtask

   initial begin
      rst = 1'b1; enter = 1'b0; clear = 1'b0; sw = 4'd0; op_sw = 3'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_v1", 32'(V1), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_cnt", 32'(ovf_cnt), 32'd0);
      rst = 1'b0;
      tick();

      // add without carry, then a single overflow
      do_op(4'd3, 4'd4, 3'd0);
      do_op(4'd9, 4'd8, 3'd0);
      chk("ovf_cnt_one", 32'(ovf_cnt), 32'd1);

      for (int i = 0; i < 12; i++)
         do_op(4'($urandom), 4'($urandom), 3'($urandom_range(0, 7)));

      // saturation: counter must stop at 15
      for (int i = 0; i < 20; i++) do_op(4'd9, 4'd8, 3'd0);
      chk("ovf_cnt_sat", 32'(ovf_cnt), 32'd15);

      // held button advances exactly once
      press(4'd5, 3'd0, 10);
      chk("hold_v1", 32'(V1), 32'd5);
      chk("hold_state", 32'(state), 32'd1);
      repeat (3) tick();
      chk("hold_no_adv", 32'(state), 32'd1);
      $display("held button: V1=%0d state=%0d", V1, state);

      // clear in WAIT_OP together with a press
      press(4'd4, 3'd0, 1);
      chk("pre_clear_state", 32'(state), 32'd2);
      enter = 1'b0;
      tick();
      sw = 4'd7; op_sw = 3'd5; enter = 1'b1; clear = 1'b1;
      tick();
      enter = 1'b0; clear = 1'b0;
      repeat (LAT) tick();
      exp_cnt = 0;
      chk("clr_state", 32'(state), 32'd0);
      chk("clr_v1", 32'(V1), 32'd0);
      chk("clr_v2", 32'(V2), 32'd0);
      chk("clr_op", 32'(OP), 32'd0);
      chk("clr_result", 32'(result), 32'd0);
      chk("clr_cnt", 32'(ovf_cnt), 32'd0);
      $display("clear: state=%0d V1=%0d cnt=%0d", state, V1, ovf_cnt);

      // async reset while in EXEC
      do_op(4'd12, 4'd7, 3'd0);
      press(4'd1, 3'd0, 1);
      press(4'd2, 3'd0, 1);
      press(4'd0, 3'd0, 1);
      chk("pre_rst_exec", 32'(state), 32'd3);
      #2 rst = 1'b1;
      #1;
      exp_cnt = 0;
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_v1", 32'(V1), 32'd0);
      chk("arst_op", 32'(OP), 32'd0);
      chk("arst_result", 32'(result), 32'd0);
      chk("arst_cnt", 32'(ovf_cnt), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      #2 rst = 1'b0;
      tick();
      chk("arst_no_done", 32'(done), 32'd0);
      chk("arst_idle", 32'(state), 32'd0);
      $display("async reset in EXEC: state=%0d done=%0d", state, done);
      do_op(4'd15, 4'd1, 3'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
